mux16_rr_arbiter: RTL
=====================

Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-to-1 selection datapath.
- Sixteen requesters compete for the single mux output. The block grants one requester at a time and drives the 4-bit select (S16) of the 16:1 mux.
- It enforces a maximum hold time so that no requester can starve the others.
- It sits between the requester bank and the mux; the consumer of f returns Done when it has taken the data.

Parameters:
- MAX_HOLD, 8, maximum cycles one grant is held before forced release (legal range 1..255).
- CW, 8, hold-counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Resetn  input  1  asynchronous active-low reset.
- Req  input  16  request lines; Req[i] means requester i wants the mux.
- Done  input  1  consumer has finished with the current selection; sampled only in GRANT.
- S16  output  4  mux select; index of the granted requester.
- Grant  output  16  one-hot grant, Grant[S16]=1 while granted, else all zero.
- Valid  output  1  high while in GRANT; mux output f is meaningful.
- Timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Clock and reset: one clock (Clock); reset is asynchronous and active-low (Resetn).
- All outputs and state are registered.
- Reset values: S16=0, Grant=0, Valid=0, Timeout=0, round-robin pointer Ptr=0, hold count Cnt=0, state=IDLE.
- Reset asserted mid-grant clears everything immediately, with no wait for a clock edge.
- State machine: IDLE, GRANT, GAP.
- IDLE, no Req bit set: stay in IDLE; S16 holds its last value; Grant=0; Valid=0.
- IDLE, any Req bit set:
  - Select the winner k = first index i in circular order Ptr, Ptr+1, …, 15, 0, …, Ptr-1 with Req[i]=1.
  - Next edge: S16=k, Grant=one-hot(k), Valid=1, Cnt=1, state=GRANT.
  - Latency from Req rising to Valid is 1 cycle.
- GRANT, release conditions, evaluated each edge in priority order:
  - (a) Done=1: normal release.
  - (b) Req[S16]=0: requester withdrew; normal release.
  - (c) Cnt==MAX_HOLD: forced release, Timeout=1 for the following cycle.
  - If none applies: Cnt=Cnt+1 and all outputs hold.
- Grant length: at most MAX_HOLD cycles of Valid.
- Done and the limit in the same cycle: (a) wins, so Timeout stays 0.
- On any release:
  - Ptr = (S16+1) mod 16; the wrap from 15 goes to 0.
  - Grant=0, Valid=0, Cnt=0, state=GAP.
  - S16 holds its value, so the mux output does not glitch during the gap.
- GAP: exactly one bubble cycle for mux settle and consumer turnaround, then unconditionally return to IDLE. Timeout is high only in this cycle, and only after a forced release.
- Minimum spacing between grants is 2 idle cycles (GAP then IDLE).
- Changes on Req lines other than Req[S16] during GRANT or GAP are ignored until the next IDLE evaluation.
- A requester that holds Req continuously is re-granted only after every other active requester has been served once (round-robin fairness).
- Done is ignored outside GRANT.
- X on Req while in IDLE is illegal; the bench must not drive it.

Test Plan:
- Reset: hold Resetn=0 with Req=16'hFFFF, then release -> S16=0, Grant=0, Valid=0, Timeout=0; first grant to index 0 one cycle after Resetn rises.
- Single requester: Req=16'h0020 (bit 5), Done pulsed on the 3rd Valid cycle -> S16=5, Grant=16'h0020, Valid high 3 cycles, 1 GAP cycle, Timeout=0, Ptr=6.
- Rotation and wrap: Ptr=14, Req=16'hC003 held, Done pulsed each grant -> grant order 14, 15, 0, 1, 14; S16 holds during each GAP.
- Hold limit: MAX_HOLD=8, Req=16'h0001 held, Done=0 -> Valid high exactly 8 cycles, then Timeout=1 for 1 cycle, then re-grant to index 0 (sole requester).
- Simultaneous Done and limit: Done=1 in the 8th Valid cycle -> normal release, Timeout stays 0.
- Withdrawal and async reset: Req[3] dropped mid-grant -> release next edge; separately, Resetn pulsed low between edges during GRANT -> Grant=0 and Valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/mux16_rr_arbiter_if.sv
// Request/grant bundle between the requester bank, the 16:1 mux and the round-robin arbiter.
interface mux16_rr_arbiter_if;
  logic [15:0] Req;
  logic        Done;
  logic [3:0]  S16;
  logic [15:0] Grant;
  logic        Valid;
  logic        Timeout;

  modport master (
    output Req,
    output Done,
    input  S16,
    input  Grant,
    input  Valid,
    input  Timeout
  );

  modport slave (
    input  Req,
    input  Done,
    output S16,
    output Grant,
    output Valid,
    output Timeout
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 mux, with a hold-time limit
// and a one-cycle gap between grants.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 8
) (
  input logic                  Clock,
  input logic                  Resetn,
  mux16_rr_arbiter_if.slave    bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

  logic [1:0]    state_q, state_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [3:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   grant_q, grant_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;

  logic [31:0]   req_rot_wide;
  logic [15:0]   req_rot;
  logic [3:0]    first_pos;
  logic [3:0]    winner;
  logic          any_req;
  logic          release_now;

  // Rotate requests so the pointer position lands at bit 0; lowest set bit wins.
  assign req_rot_wide = {bus.Req, bus.Req} >> ptr_q;
  assign req_rot      = req_rot_wide[15:0];
  assign any_req      = |bus.Req;

  always_comb begin
    first_pos = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) begin
        first_pos = 4'(i);
      end
    end
  end

  assign winner      = ptr_q + first_pos;
  assign release_now = bus.Done || !bus.Req[sel_q] || (cnt_q == HOLD_LIMIT);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (any_req) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = 16'd1 << winner;
          valid_d = 1'b1;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d   = GAP;
          ptr_d     = sel_q + 4'd1;
          grant_d   = '0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          // Only a hold-limit release is flagged; Done and withdrawal take precedence.
          timeout_d = !bus.Done && bus.Req[sel_q];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      ptr_q     <= 4'd0;
      sel_q     <= 4'd0;
      cnt_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.S16     = sel_q;
  assign bus.Grant   = grant_q;
  assign bus.Valid   = valid_q;
  assign bus.Timeout = timeout_q;

endmodule
